// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the M-stage data memory responder.
// Loader FSM encodings, MMIO register offsets and the default MMIO base.
package data_mem_responder_pkg;

  typedef logic [1:0] ld_state_t;

  localparam ld_state_t ST_IDLE   = 2'd0;
  localparam ld_state_t ST_ASSM   = 2'd1;
  localparam ld_state_t ST_COMMIT = 2'd2;
  localparam ld_state_t ST_DONE   = 2'd3;

  // MMIO register select, taken from address bits [3:2]
  localparam logic [1:0] MMIO_CNT  = 2'd0;
  localparam logic [1:0] MMIO_STAT = 2'd1;
  localparam logic [1:0] MMIO_WCNT = 2'd2;

  localparam logic [31:0] MMIO_BASE_DEF = 32'hFFFF_FF00;

  function automatic logic in_mmio(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:4] == base[31:4];
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Core M-stage data port plus byte-serial bulk loader port.
interface data_mem_responder_if;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        core_stall;

  logic        ld_start;
  logic [31:0] ld_base;
  logic [15:0] ld_len;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_ready;
  logic        ld_done;

  modport slave (
    input  mem_we, mem_addr, mem_wdata,
    input  ld_start, ld_base, ld_len, ld_valid, ld_byte,
    output mem_rdata, core_stall, ld_ready, ld_done
  );

  modport master (
    output mem_we, mem_addr, mem_wdata,
    output ld_start, ld_base, ld_len, ld_valid, ld_byte,
    input  mem_rdata, core_stall, ld_ready, ld_done
  );
endinterface

// File: rtl/data_mem_responder_byte_word_assembler.sv
// Packs accepted loader bytes little-endian into a 32-bit word;
// word_valid strobes on the byte that completes the word.
module byte_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0] idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx  <= 2'd0;
      word <= 32'd0;
    end else if (clr) begin
      idx <= 2'd0;
    end else if (accept) begin
      word[{idx, 3'b000} +: 8] <= byte_in;
      idx                      <= idx + 2'd1;
    end
  end

  assign word_valid = accept & (idx == 2'd3);

endmodule

// File: rtl/data_mem_responder.sv
// Word RAM with same-cycle read, MMIO window (cycle counter, loader status)
// and a byte-serial bulk loader that stalls the core while it owns the RAM.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  data_mem_responder_if.slave   bus
);

  //  state  | meaning
  //  IDLE   | core owns RAM, waiting for ld_start
  //  ASSM   | accepting loader bytes into the word assembler
  //  COMMIT | writing assembled word to base + 4*cnt
  //  DONE   | one-cycle ld_done pulse, sets done_sticky

  localparam int AW = $clog2(DEPTH);

  logic [31:0] ram [DEPTH];

  ld_state_t   state;
  logic [31:0] base_q;
  logic [15:0] len_q;
  logic [15:0] cnt_q;
  logic [31:0] cyc_q;
  logic        done_sticky;
  logic        overrun;
  logic        zero_done_q;

  logic        stall;
  logic        core_in_ram;
  logic        core_in_mmio;
  logic [1:0]  mmio_sel;
  logic        core_wr;
  logic [31:0] ld_addr;
  logic        ld_in_ram;
  logic        ld_commit;
  logic        start_load;
  logic        accept;
  logic [31:0] asm_word;
  logic        word_valid;
  logic        cnt_clr;
  logic        stat_clr;
  logic        ovr_set;
  logic        done_set;

  assign stall        = (state != ST_IDLE);
  assign core_in_ram  = (bus.mem_addr[31:AW+2] == '0);
  assign core_in_mmio = in_mmio(bus.mem_addr, MMIO_BASE);
  assign mmio_sel     = bus.mem_addr[3:2];
  assign core_wr      = bus.mem_we & ~stall;
  assign ld_addr      = base_q + {14'd0, cnt_q, 2'b00};
  assign ld_in_ram    = (ld_addr[31:AW+2] == '0);
  assign ld_commit    = (state == ST_COMMIT);
  assign start_load   = (state == ST_IDLE) & bus.ld_start & (bus.ld_len != 16'd0);
  assign accept       = bus.ld_valid & bus.ld_ready;

  assign cnt_clr  = core_wr & core_in_mmio & (mmio_sel == MMIO_CNT);
  assign stat_clr = core_wr & core_in_mmio & (mmio_sel == MMIO_STAT);
  // a stalled core write and an out-of-range loader word both count as overrun
  assign ovr_set  = (bus.mem_we & stall) | (ld_commit & ~ld_in_ram);
  assign done_set = (state == ST_DONE) |
                    ((state == ST_IDLE) & bus.ld_start & (bus.ld_len == 16'd0));

  assign bus.core_stall = stall;
  assign bus.ld_ready   = (state == ST_ASSM);
  assign bus.ld_done    = (state == ST_DONE) | zero_done_q;

  wire unused_addr_bits = ^{bus.mem_addr[1:0], ld_addr[1:0]};

  byte_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_load),
    .accept     (accept),
    .byte_in    (bus.ld_byte),
    .word       (asm_word),
    .word_valid (word_valid)
  );

  // RAM is not reset; core and loader writes are exclusive via stall
  always_ff @(posedge clk) begin
    if (core_wr & core_in_ram)
      ram[bus.mem_addr[AW+1:2]] <= bus.mem_wdata;
    else if (ld_commit & ld_in_ram)
      ram[ld_addr[AW+1:2]] <= asm_word;
  end

  always_comb begin
    bus.mem_rdata = 32'd0;
    if (core_in_ram) begin
      bus.mem_rdata = ram[bus.mem_addr[AW+1:2]];
    end else if (core_in_mmio) begin
      case (mmio_sel)
        MMIO_CNT:  bus.mem_rdata = cyc_q;
        MMIO_STAT: bus.mem_rdata = {29'd0, overrun, stall, done_sticky};
        MMIO_WCNT: bus.mem_rdata = {16'd0, cnt_q};
        default:   bus.mem_rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      base_q      <= 32'd0;
      len_q       <= 16'd0;
      cnt_q       <= 16'd0;
      zero_done_q <= 1'b0;
    end else begin
      zero_done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.ld_start) begin
            if (bus.ld_len != 16'd0) begin
              state  <= ST_ASSM;
              base_q <= bus.ld_base;
              len_q  <= bus.ld_len;
              cnt_q  <= 16'd0;
            end else begin
              zero_done_q <= 1'b1;
            end
          end
        end
        ST_ASSM: begin
          if (word_valid) state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          cnt_q <= cnt_q + 16'd1;
          state <= (cnt_q + 16'd1 == len_q) ? ST_DONE : ST_ASSM;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q       <= 32'd0;
      done_sticky <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      cyc_q <= cnt_clr ? 32'd0 : cyc_q + 32'd1;
      if (ovr_set)       overrun <= 1'b1;
      else if (stat_clr) overrun <= 1'b0;
      if (done_set)      done_sticky <= 1'b1;
      else if (stat_clr) done_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed-vector bench for data_mem_responder: core access, MMIO, bulk loader,
// overrun handling and asynchronous reset during a load.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if bus();

  data_mem_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nvec = 0;
  int nmis = 0;
  logic [7:0] bq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.mem_addr = a;
    #1;
    chk(tag, bus.mem_rdata, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.mem_we    = 1'b1;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    tick();
    bus.mem_we    = 1'b0;
  endtask

  task automatic feed(input logic [7:0] b, input int gap, input bit gap_ready);
    int budget;
    budget       = 0;
    bus.ld_valid = 1'b1;
    bus.ld_byte  = b;
    while (!bus.ld_ready && budget < 20) begin
      tick();
      budget++;
    end
    if (!bus.ld_ready) chk("ready_timeout", {31'd0, bus.ld_ready}, 32'd1);
    chk("stall_in_load", {31'd0, bus.core_stall}, 32'd1);
    tick();
    bus.ld_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      if (gap_ready) chk("ready_held", {31'd0, bus.ld_ready}, 32'd1);
      tick();
    end
  endtask

  task automatic ld_begin(input logic [31:0] base, input logic [15:0] len);
    bus.ld_start = 1'b1;
    bus.ld_base  = base;
    bus.ld_len   = len;
    tick();
    bus.ld_start = 1'b0;
    chk("stall_after_start", {31'd0, bus.core_stall}, 32'd1);
  endtask

  task automatic ld_finish(input int gap);
    for (int i = 0; i < bq.size(); i++)
      feed(bq[i], (i == bq.size() - 1) ? 0 : gap, (i % 4) != 3);
    chk("done_low_in_commit", {31'd0, bus.ld_done}, 32'd0);
    chk("ready_low_in_commit", {31'd0, bus.ld_ready}, 32'd0);
    tick();
    chk("done_pulse", {31'd0, bus.ld_done}, 32'd1);
    chk("stall_in_done", {31'd0, bus.core_stall}, 32'd1);
    tick();
    chk("done_one_cycle", {31'd0, bus.ld_done}, 32'd0);
    chk("stall_released", {31'd0, bus.core_stall}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'd0;
    bus.mem_wdata = 32'd0;
    bus.ld_start  = 1'b0;
    bus.ld_base   = 32'd0;
    bus.ld_len    = 16'd0;
    bus.ld_valid  = 1'b0;
    bus.ld_byte   = 8'd0;

    // reset state and cycle counter
    repeat (3) tick();
    chk("rst_stall", {31'd0, bus.core_stall}, 32'd0);
    chk("rst_ready", {31'd0, bus.ld_ready}, 32'd0);
    chk("rst_done", {31'd0, bus.ld_done}, 32'd0);
    rst = 1'b1;
    chk_rd("rst_counter", 32'hFFFF_FF00, 32'd0);
    repeat (3) tick();
    chk_rd("counter_3", 32'hFFFF_FF00, 32'd3);
    chk_rd("rst_status", 32'hFFFF_FF04, 32'd0);
    chk_rd("rst_words", 32'hFFFF_FF08, 32'd0);

    // core write/read, out-of-range, MMIO +C
    wr(32'h10, 32'hDEAD_BEEF);
    chk_rd("core_rd_10", 32'h10, 32'hDEAD_BEEF);
    chk_rd("oor_rd", 32'h1000, 32'd0);
    wr(32'h1010, 32'h0BAD_F00D);
    chk_rd("oor_no_alias", 32'h10, 32'hDEAD_BEEF);
    chk_rd("mmio_c", 32'hFFFF_FF0C, 32'd0);
    wr(32'h204, 32'hCAFE_F00D);
    wr(32'h0, 32'd0);

    // back-to-back load
    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    ld_begin(32'h40, 16'd2);
    ld_finish(0);
    chk_rd("load_w0", 32'h40, 32'h4433_2211);
    chk_rd("load_w1", 32'h44, 32'h8877_6655);
    chk_rd("load_count", 32'hFFFF_FF08, 32'd2);
    chk_rd("load_status", 32'hFFFF_FF04, 32'd1);
    wr(32'hFFFF_FF04, 32'd0);
    chk_rd("sticky_clr", 32'hFFFF_FF04, 32'd0);

    // same load with 3-cycle gaps between bytes
    ld_begin(32'h80, 16'd2);
    ld_finish(3);
    chk_rd("gap_w0", 32'h80, 32'h4433_2211);
    chk_rd("gap_w1", 32'h84, 32'h8877_6655);

    // core write during load is dropped and flags overrun
    wr(32'hFFFF_FF04, 32'd0);
    bq = '{8'h01, 8'h02, 8'h03, 8'h04};
    ld_begin(32'h100, 16'd1);
    wr(32'h10, 32'h1234_5678);
    ld_finish(0);
    chk_rd("stalled_wr_dropped", 32'h10, 32'hDEAD_BEEF);
    chk_rd("ovr_word", 32'h100, 32'h0403_0201);
    chk_rd("ovr_status", 32'hFFFF_FF04, 32'd5);
    wr(32'hFFFF_FF04, 32'hFFFF_FFFF);
    chk_rd("ovr_clr", 32'hFFFF_FF04, 32'd0);

    // loader word past end of RAM
    bq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    ld_begin(32'hFFC, 16'd2);
    ld_finish(0);
    chk_rd("edge_word", 32'hFFC, 32'h1312_1110);
    chk_rd("edge_no_wrap", 32'h0, 32'd0);
    chk_rd("edge_count", 32'hFFFF_FF08, 32'd2);
    chk_rd("edge_status", 32'hFFFF_FF04, 32'd5);
    wr(32'hFFFF_FF04, 32'd0);

    // counter clear
    repeat (4) tick();
    wr(32'hFFFF_FF00, 32'h5A5A_5A5A);
    chk_rd("cnt_clr", 32'hFFFF_FF00, 32'd0);
    tick();
    chk_rd("cnt_after_clr", 32'hFFFF_FF00, 32'd1);

    // zero-length start
    bus.ld_start = 1'b1;
    bus.ld_base  = 32'h300;
    bus.ld_len   = 16'd0;
    tick();
    bus.ld_start = 1'b0;
    chk("zero_done", {31'd0, bus.ld_done}, 32'd1);
    chk("zero_no_stall", {31'd0, bus.core_stall}, 32'd0);
    tick();
    chk("zero_done_clr", {31'd0, bus.ld_done}, 32'd0);
    chk("zero_no_stall2", {31'd0, bus.core_stall}, 32'd0);

    // reset after 5 bytes of a 2-word load
    bq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    ld_begin(32'h200, 16'd2);
    for (int i = 0; i < 5; i++) feed(bq[i], 0, 1'b0);
    rst = 1'b0;
    #1;
    chk("midrst_stall", {31'd0, bus.core_stall}, 32'd0);
    chk("midrst_ready", {31'd0, bus.ld_ready}, 32'd0);
    chk("midrst_done", {31'd0, bus.ld_done}, 32'd0);
    rst = 1'b1;
    chk_rd("midrst_w0", 32'h200, 32'hA4A3_A2A1);
    chk_rd("midrst_w1", 32'h204, 32'hCAFE_F00D);
    chk_rd("midrst_count", 32'hFFFF_FF08, 32'd0);
    chk_rd("midrst_status", 32'hFFFF_FF04, 32'd0);
    chk_rd("midrst_counter", 32'hFFFF_FF00, 32'd0);
    tick();
    chk("midrst_idle", {31'd0, bus.core_stall}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
